muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Iterative multiply/divide sequencer for the execute stage. It sits beside the single-cycle ALU.
//  It accepts one M-extension op at a time over a valid/ready handshake, then runs a shift-add
//  multiplier or a restoring divider for XLEN (or 32) iterations. It returns the result over a
//  second valid/ready handshake; the pipeline stalls on !req_ready or !resp_valid.
// PARAMETERS
//  XLEN   64   datapath width; word_t width
//  WLEN   32   width used when is_word=1 (RV64 *W ops)
// PORTS
//  clk          in   1     clock, all state on rising edge
//  resetn       in   1     asynchronous, active-low reset
//  flush        in   1     sync kill of in-flight op (branch mispredict / trap)
//  req_valid    in   1     op request valid
//  req_ready    out  1     sequencer can accept (state IDLE)
//  req_op       in   3     0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU; 5-7 reserved
//  req_word     in   1     operate on low WLEN bits, sign-extend result to XLEN
//  req_a        in   XLEN  operand a (multiplicand / dividend)
//  req_b        in   XLEN  operand b (multiplier / divisor)
//  resp_valid   out  1     result valid (state DONE)
//  resp_ready   in   1     consumer takes result
//  resp_result  out  XLEN  result
// BEHAVIOUR
//  Reset (resetn=0, async): state=IDLE, counter=0, resp_valid=0, resp_result=0, req_ready=1.
//  States: IDLE -> BUSY -> DONE -> IDLE; IDLE -> DONE for special cases.
//  IDLE: req_ready=1. Accept on clock edge with req_valid&&req_ready&&!flush.
//   Latch op/word; preprocess operands.
//   - word: take [WLEN-1:0], sign- or zero-extend per op.
//   - signed div/rem: take magnitudes and record quotient/remainder signs.
//   Set counter = N, where N = WLEN if word else XLEN. Go to BUSY.
//  Special cases are decided at accept and go straight to DONE (latency 1):
//   - divisor==0: DIV/DIVU -> all ones; REM/REMU -> dividend.
//   - signed overflow (a=most-negative, b=-1): DIV -> a; REM -> 0.
//   - Both are evaluated at the effective width N; the result is then sign-extended if word.
//  BUSY: one iteration per cycle; counter decrements.
//   MUL: if mplier[0], acc+=mcand; mcand<<=1; mplier>>=1; keep low N bits only.
//   DIV: rem={rem,quo[N-1]}; quo<<=1; if rem>=divisor {rem-=divisor; quo[0]=1}.
//   On the edge where counter goes 1->0: post-process (negate by recorded signs, select
//   quo/rem, sign-extend bit 31 if word), register resp_result, go to DONE.
//  Latency: accept edge T -> resp_valid high from cycle T+N+1 (65 for XLEN, 33 for word ops).
//  DONE: resp_valid=1 and resp_result stable until the edge with resp_ready=1.
//   That edge returns to IDLE and clears resp_valid. No new request is accepted in DONE
//   (req_ready=0), so there is no back-to-back overlap.
//  flush: sampled every edge, priority over all other transitions.
//   - Any state -> IDLE; resp_valid=0; the in-flight result is discarded.
//   - flush with req_valid in IDLE: request is NOT accepted.
//   - flush with resp_ready in DONE: treated as flush (result dropped, no error).
//  Reserved req_op: accepted, goes straight to DONE, result 0.
//  Internal widths: acc/quo/rem/mcand are XLEN bits, masked to N; no wrap beyond N.
//  Inputs are sampled only at accept; later changes to req_* are ignored.
// TESTING
//  1. MUL a=7,b=-3 (64b) -> resp_valid at T+65, result 0xFFFF_FFFF_FFFF_FFEB.
//  2. DIV a=-20,b=6 -> quotient -3 (0xFFFF_FFFF_FFFF_FFFD); REM same operands -> -2.
//  3. DIVU a=5,b=0 -> result all ones at T+1; REMU a=5,b=0 -> 5 at T+1.
//  4. DIV word a=0x8000_0000,b=-1 -> 0xFFFF_FFFF_8000_0000 at T+1; REM word -> 0.
//  5. MULW a=0x0001_0000,b=0x0001_0000 -> low 32 = 0 -> result 0 at T+33.
//     Then hold resp_ready=0 for 5 cycles -> result stable, req_ready=0.
//  6. flush at T+10 of a DIVU -> IDLE next edge, resp_valid never rises.
//     resetn low mid-BUSY -> all outputs at reset values immediately.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer for M-extension ops.
// It takes one op at a time over a valid/ready request handshake. It runs a
// shift-add multiplier or a restoring divider, one bit per cycle, for XLEN
// iterations, or WLEN iterations for word ops. The result comes back over a
// valid/ready response handshake.
// Ports:
//   clk, resetn (async, active-low), flush (sync kill of in-flight op)
//   req_valid/req_ready, req_op (0 MUL,1 DIV,2 DIVU,3 REM,4 REMU,5-7 rsvd),
//   req_word, req_a, req_b      : request side, sampled only at accept
//   resp_valid/resp_ready, resp_result : response side, held until taken
module muldiv_seq #(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] NX = CW'(XLEN);
  localparam logic [CW-1:0] NW = CW'(WLEN);
  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_REM  = 3'd3;
  localparam logic [2:0] OP_REMU = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic [XLEN-1:0] wmask(input logic word);
    return word ? {{(XLEN-WLEN){1'b0}}, {WLEN{1'b1}}} : {XLEN{1'b1}};
  endfunction

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] finalize(input logic [XLEN-1:0] v, input logic word);
    return word ? sext_w(v) : v;
  endfunction

  state_t          state, state_d;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic            word_q, qneg_q, rneg_q;
  // Shared datapath: a_q = multiplicand / quotient, b_q = multiplier / divisor,
  // acc_q = product accumulator / partial remainder.
  logic [XLEN-1:0] a_q, b_q, acc_q;

  // Accept-side preprocessing
  logic            accept, sgn, a_neg, b_neg, div0, ovf, is_div, rsvd, special;
  logic [XLEN-1:0] mask_r, minv, a_ext, b_ext, a_mag, b_mag, special_res;

  always_comb begin
    accept  = (state == S_IDLE) && req_valid && !flush;
    sgn     = (req_op == OP_DIV) || (req_op == OP_REM);
    is_div  = (req_op >= OP_DIV) && (req_op <= OP_REMU);
    rsvd    = req_op > OP_REMU;
    mask_r  = wmask(req_word);
    minv    = mask_r ^ (mask_r >> 1);
    a_ext   = req_a;
    b_ext   = req_b;
    if (req_word) begin
      a_ext = sgn ? sext_w(req_a) : (req_a & mask_r);
      b_ext = sgn ? sext_w(req_b) : (req_b & mask_r);
    end
    a_neg   = sgn && a_ext[XLEN-1];
    b_neg   = sgn && b_ext[XLEN-1];
    a_mag   = (a_neg ? -a_ext : a_ext) & mask_r;
    b_mag   = (b_neg ? -b_ext : b_ext) & mask_r;
    div0    = (b_ext & mask_r) == '0;
    ovf     = sgn && ((a_ext & mask_r) == minv) && ((b_ext & mask_r) == mask_r);
    special = rsvd || (is_div && (div0 || ovf));
    special_res = '0;
    if (is_div && div0)
      special_res = ((req_op == OP_DIV) || (req_op == OP_DIVU)) ? {XLEN{1'b1}}
                                                                : finalize(a_ext & mask_r, req_word);
    else if (is_div && ovf)
      special_res = (req_op == OP_DIV) ? finalize(a_ext & mask_r, req_word) : '0;
  end

  // One iteration of the selected algorithm
  logic            is_mul_q, msb, ge, neg;
  logic [XLEN-1:0] mask_q, a_nx, b_nx, acc_nx, sel, fin;
  logic [XLEN:0]   rem_sh;

  always_comb begin
    is_mul_q = op_q == OP_MUL;
    mask_q   = wmask(word_q);
    msb      = word_q ? a_q[WLEN-1] : a_q[XLEN-1];
    // Partial remainder stays below the divisor, so one extra bit covers the shift.
    rem_sh   = {acc_q, msb};
    ge       = rem_sh >= {1'b0, b_q};
    if (is_mul_q) begin
      a_nx   = (a_q << 1) & mask_q;
      b_nx   = b_q >> 1;
      acc_nx = (acc_q + (b_q[0] ? a_q : '0)) & mask_q;
    end else begin
      a_nx   = ((a_q << 1) | {{(XLEN-1){1'b0}}, ge}) & mask_q;
      b_nx   = b_q;
      acc_nx = ge ? (rem_sh[XLEN-1:0] - b_q) : rem_sh[XLEN-1:0];
    end
    sel = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? a_nx : acc_nx;
    neg = ((op_q == OP_DIV) && qneg_q) || ((op_q == OP_REM) && rneg_q);
    fin = finalize((neg ? -sel : sel) & mask_q, word_q);
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (accept) state_d = special ? S_DONE : S_BUSY;
      S_BUSY:  if (cnt == CW'(1)) state_d = S_DONE;
      S_DONE:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  assign req_ready  = state == S_IDLE;
  assign resp_valid = state == S_DONE;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      resp_result <= '0;
    end else begin
      state <= state_d;
      if (flush) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= special ? '0 : (req_word ? NW : NX);
        if (special) resp_result <= special_res;
      end else if (state == S_BUSY) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) resp_result <= fin;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= req_op;
      word_q <= req_word;
      qneg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      a_q    <= a_mag;
      b_q    <= b_mag;
      acc_q  <= '0;
    end else if (state == S_BUSY) begin
      a_q    <= a_nx;
      b_q    <= b_nx;
      acc_q  <= acc_nx;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, results, hold, flush and async reset.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic        req_word = 1'b0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_result;

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  muldiv_seq #(.XLEN(64), .WLEN(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_word(req_word), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op, check resp_valid rises exactly lat edges after accept,
  // check the result, optionally stall the consumer, then take the result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic word,
                        input logic [63:0] a, input logic [63:0] b,
                        input int lat, input logic [63:0] exp, input int hold);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_word = word; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = ~a; req_b = ~b; req_op = 3'd7; req_word = ~word;
    chk({tag, "_rdy_low"}, {63'd0, req_ready}, 64'd0);
    if (lat > 0) begin
      repeat (lat - 1) @(posedge clk);
      #1 chk({tag, "_not_early"}, {63'd0, resp_valid}, 64'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_valid"}, {63'd0, resp_valid}, 64'd1);
    chk({tag, "_result"}, resp_result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {63'd0, resp_valid}, 64'd1);
      chk({tag, "_hold_result"}, resp_result, exp);
      chk({tag, "_hold_rdy"}, {63'd0, req_ready}, 64'd0);
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    chk({tag, "_taken"}, {63'd0, resp_valid}, 64'd0);
    chk({tag, "_idle"}, {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    int seen;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_result", resp_result, 64'd0);
    @(negedge clk); resetn = 1'b1;

    run_op("mul_7_m3",  3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    run_op("div_m20_6", 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("rem_m20_6", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op("divu_100_7", 3'd2, 1'b0, 64'd100, 64'd7, 64, 64'd14, 0);
    run_op("divu_by0",  3'd2, 1'b0, 64'd5, 64'd0, 0, ONES, 0);
    run_op("remu_by0",  3'd4, 1'b0, 64'd5, 64'd0, 0, 64'd5, 0);
    run_op("divw_ovf",  3'd1, 1'b1, 64'h0000_0000_8000_0000, ONES, 0, 64'hFFFF_FFFF_8000_0000, 0);
    run_op("remw_ovf",  3'd3, 1'b1, 64'h0000_0000_8000_0000, ONES, 0, 64'd0, 0);
    run_op("div_ovf64", 3'd1, 1'b0, 64'h8000_0000_0000_0000, ONES, 0, 64'h8000_0000_0000_0000, 0);
    run_op("rsvd_op",   3'd5, 1'b0, 64'd9, 64'd3, 0, 64'd0, 0);
    run_op("mulw_wrap", 3'd0, 1'b1, 64'h0000_0000_0001_0000, 64'h0000_0000_0001_0000, 32, 64'd0, 5);
    run_op("mulw_neg",  3'd0, 1'b1, 64'h0000_0000_FFFF_FFFD, 64'd5, 32, 64'hFFFF_FFFF_FFFF_FFF1, 0);
    run_op("divuw_mask", 3'd2, 1'b1, 64'h0000_0001_0000_0064, 64'd7, 32, 64'd14, 0);
    run_op("remw_m7_2", 3'd3, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 32, ONES, 0);

    // Flush mid-BUSY: result never appears
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd2; req_word = 1'b0; req_a = 64'd100; req_b = 64'd7;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_busy_idle", {63'd0, req_ready}, 64'd1);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    chk("flush_busy_no_valid", 64'(seen), 64'd0);

    // Flush with req_valid in IDLE: not accepted (a div-by-zero would be DONE at once)
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_op = 3'd2; req_a = 64'd5; req_b = 64'd0;
    @(posedge clk); #1; req_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_noaccept_valid", {63'd0, resp_valid}, 64'd0);
    chk("flush_idle_noaccept_rdy", {63'd0, req_ready}, 64'd1);

    // Flush together with resp_ready in DONE
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd2; req_a = 64'd5; req_b = 64'd0;
    @(posedge clk); #1; req_valid = 1'b0;
    chk("flush_done_valid", {63'd0, resp_valid}, 64'd1);
    chk("flush_done_result", resp_result, ONES);
    @(negedge clk); flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1; flush = 1'b0; resp_ready = 1'b0;
    chk("flush_done_dropped", {63'd0, resp_valid}, 64'd0);
    chk("flush_done_idle", {63'd0, req_ready}, 64'd1);

    // Async reset mid-BUSY
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_a = 64'd7; req_b = 64'd3;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("areset_req_ready", {63'd0, req_ready}, 64'd1);
    chk("areset_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("areset_result", resp_result, 64'd0);
    @(negedge clk); resetn = 1'b1;
    run_op("after_reset", 3'd4, 1'b0, 64'd100, 64'd7, 64, 64'd2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
